sram_port_arbiter: RTL

Two-requester arbiter and sequencer for one single-port SRAM macro (TS1N16ADFPCLLLVTA512X45M4SWSHOD-style interface: CEB/WEB/A/D/BWEB/Q, 1-cycle read latency).
- Requester 0 and requester 1 share the macro; each presents one word read/write per request.
- Round-robin arbitration; exactly one access in flight; each access returns one response.
- Sits between the AXI slave-side front ends and the SRAM macro instance.

---
 rtl/sram_port_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port SRAM macro between two requesters.
// One access in flight at a time; each accepted access returns exactly one response.
module sram_port_arbiter #(
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned DATA_W = 32
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic                req0_we,
   input  logic [ADDR_W-1:0]   req0_addr,
   input  logic [DATA_W-1:0]   req0_wdata,
   input  logic [DATA_W/8-1:0] req0_wstrb,
   output logic                rsp0_valid,
   input  logic                rsp0_ready,
   output logic [DATA_W-1:0]   rsp0_rdata,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic                req1_we,
   input  logic [ADDR_W-1:0]   req1_addr,
   input  logic [DATA_W-1:0]   req1_wdata,
   input  logic [DATA_W/8-1:0] req1_wstrb,
   output logic                rsp1_valid,
   input  logic                rsp1_ready,
   output logic [DATA_W-1:0]   rsp1_rdata,
   output logic [1:0]          grant,
   output logic                CEB,
   output logic                WEB,
   output logic [ADDR_W-1:0]   A,
   output logic [DATA_W-1:0]   D,
   output logic [DATA_W-1:0]   BWEB,
   input  logic [DATA_W-1:0]   Q
);

   localparam int unsigned STRB_W = DATA_W / 8;

   typedef enum logic {StIdle, StResp} state_e;

   state_e state_q, state_d;
   logic   owner_q, owner_d;       // 1 = requester 1 owns the access
   logic   read_q, read_d;
   logic   last_grant_q, last_grant_d;

   logic                win1;
   logic                win_we;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_wdata;
   logic [STRB_W-1:0]   win_wstrb;

   // Arbitration looks only at valids; on a tie the requester not served last wins.
   always_comb begin
      win1      = req1_valid & (~req0_valid | ~last_grant_q);
      win_we    = win1 ? req1_we    : req0_we;
      win_addr  = win1 ? req1_addr  : req0_addr;
      win_wdata = win1 ? req1_wdata : req0_wdata;
      win_wstrb = win1 ? req1_wstrb : req0_wstrb;
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      read_d       = read_q;
      last_grant_d = last_grant_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      rsp0_valid   = 1'b0;
      rsp1_valid   = 1'b0;
      rsp0_rdata   = '0;
      rsp1_rdata   = '0;
      grant        = 2'b00;
      CEB          = 1'b1;
      WEB          = 1'b1;
      A            = '0;
      D            = '0;
      BWEB         = '1;
      // Outputs are gated by RST so an asserted reset takes effect without a clock edge.
      if (!RST) begin
         unique case (state_q)
            StIdle: begin
               if (req0_valid || req1_valid) begin
                  req0_ready   = ~win1;
                  req1_ready   = win1;
                  grant        = win1 ? 2'b10 : 2'b01;
                  CEB          = 1'b0;
                  WEB          = ~win_we;
                  A            = win_addr;
                  if (win_we) begin
                     D = win_wdata;
                     for (int k = 0; k < STRB_W; k++) begin
                        BWEB[8*k +: 8] = {8{~win_wstrb[k]}};
                     end
                  end
                  state_d      = StResp;
                  owner_d      = win1;
                  read_d       = ~win_we;
                  last_grant_d = win1;
               end
            end
            StResp: begin
               grant = owner_q ? 2'b10 : 2'b01;
               if (owner_q) begin
                  rsp1_valid = 1'b1;
                  rsp1_rdata = read_q ? Q : '0;
                  if (rsp1_ready) state_d = StIdle;
               end else begin
                  rsp0_valid = 1'b1;
                  rsp0_rdata = read_q ? Q : '0;
                  if (rsp0_ready) state_d = StIdle;
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= StIdle;
         owner_q      <= 1'b0;
         read_q       <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         read_q       <= read_d;
         last_grant_q <= last_grant_d;
      end
   end

endmodule
